// File: rtl/sdm_audio_pkg.sv
// Shared types and sizes for the SDM audio path and its I2S output stage.
package sdm_audio_pkg;

  localparam int unsigned AUDIO_W   = 16;
  localparam int unsigned I2S_SLOTS = 2 * AUDIO_W;
  localparam int unsigned SLOT_W    = $clog2(I2S_SLOTS);

  typedef logic signed [AUDIO_W-1:0] audio_t;

  // One stereo frame as it sits in the shift register, left word in the MSBs
  typedef struct packed {
    audio_t left;
    audio_t right;
  } i2s_frame_t;

endpackage

// File: rtl/i2s_tx_if.sv
// Sample-input and I2S-output bundle of the stereo I2S transmitter.
interface i2s_tx_if;
  import sdm_audio_pkg::*;

  logic   valid_in_l;
  audio_t audio_in_l;
  logic   valid_in_r;
  audio_t audio_in_r;
  logic   i2s_bclk;
  logic   i2s_lrclk;
  logic   i2s_sdata;
  logic   frame_start;
  logic   overrun_l;
  logic   overrun_r;
  logic   underrun;

  modport master (
    output valid_in_l, audio_in_l, valid_in_r, audio_in_r,
    input  i2s_bclk, i2s_lrclk, i2s_sdata, frame_start,
    input  overrun_l, overrun_r, underrun
  );

  modport slave (
    input  valid_in_l, audio_in_l, valid_in_r, audio_in_r,
    output i2s_bclk, i2s_lrclk, i2s_sdata, frame_start,
    output overrun_l, overrun_r, underrun
  );

endinterface

// File: rtl/i2s_bclk_gen.sv
// Bit-clock divider: BCLK toggles every BCLK_DIV clk cycles; fall_c_o marks
// the cycle whose edge takes BCLK from 1 to 0.
module i2s_bclk_gen #(
  parameter int unsigned BCLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic bclk_o,
  output logic fall_c_o
);

  localparam int unsigned CNT_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bclk_q, bclk_d;
  logic             tc_c;

  always_comb begin
    tc_c   = (cnt_q == CNT_W'(BCLK_DIV - 1));
    cnt_d  = tc_c ? '0 : cnt_q + CNT_W'(1);
    bclk_d = tc_c ? ~bclk_q : bclk_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      bclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      bclk_q <= bclk_d;
    end
  end

  assign bclk_o   = bclk_q;
  assign fall_c_o = tc_c & bclk_q;

endmodule

// File: rtl/i2s_tx.sv
// Stereo Philips-I2S master: one pending sample per channel, repeat-last on
// underrun, 32-slot frame with the left MSB in slot 1.
module i2s_tx
  import sdm_audio_pkg::*;
#(
  parameter int unsigned BCLK_DIV = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  i2s_tx_if.slave  bus
);

  logic                 bclk, fall_c, load_c;
  i2s_frame_t           frame_c;

  audio_t               pend_l_q, pend_l_d, pend_r_q, pend_r_d;
  logic                 pend_vld_l_q, pend_vld_l_d, pend_vld_r_q, pend_vld_r_d;
  audio_t               last_l_q, last_l_d, last_r_q, last_r_d;
  logic [SLOT_W-1:0]    slot_q, slot_d;
  logic [I2S_SLOTS-1:0] shift_q, shift_d;
  logic                 lrclk_q, lrclk_d;
  logic                 frame_start_q, frame_start_d;
  logic                 overrun_l_q, overrun_l_d, overrun_r_q, overrun_r_d;
  logic                 underrun_q, underrun_d;

  i2s_bclk_gen #(.BCLK_DIV(BCLK_DIV)) u_bclk_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .bclk_o   (bclk),
    .fall_c_o (fall_c)
  );

  always_comb begin
    pend_l_d      = pend_l_q;
    pend_r_d      = pend_r_q;
    pend_vld_l_d  = pend_vld_l_q;
    pend_vld_r_d  = pend_vld_r_q;
    last_l_d      = last_l_q;
    last_r_d      = last_r_q;
    slot_d        = slot_q;
    shift_d       = shift_q;
    frame_start_d = 1'b0;
    overrun_l_d   = 1'b0;
    overrun_r_d   = 1'b0;
    underrun_d    = 1'b0;

    load_c        = fall_c && (slot_q == '0);
    frame_c.left  = pend_vld_l_q ? pend_l_q : last_l_q;
    frame_c.right = pend_vld_r_q ? pend_r_q : last_r_q;

    if (fall_c) begin
      slot_d  = slot_q + SLOT_W'(1);
      shift_d = load_c ? frame_c : {shift_q[I2S_SLOTS-2:0], 1'b0};
    end

    // Load consumes the old pending values; a same-cycle valid refills below
    if (load_c) begin
      last_l_d      = frame_c.left;
      last_r_d      = frame_c.right;
      pend_vld_l_d  = 1'b0;
      pend_vld_r_d  = 1'b0;
      frame_start_d = 1'b1;
      underrun_d    = ~(pend_vld_l_q & pend_vld_r_q);
    end

    if (bus.valid_in_l) begin
      pend_l_d     = bus.audio_in_l;
      pend_vld_l_d = 1'b1;
      overrun_l_d  = pend_vld_l_q & ~load_c;
    end

    if (bus.valid_in_r) begin
      pend_r_d     = bus.audio_in_r;
      pend_vld_r_d = 1'b1;
      overrun_r_d  = pend_vld_r_q & ~load_c;
    end

    lrclk_d = (slot_d >= SLOT_W'(AUDIO_W));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_l_q      <= '0;
      pend_r_q      <= '0;
      pend_vld_l_q  <= 1'b0;
      pend_vld_r_q  <= 1'b0;
      last_l_q      <= '0;
      last_r_q      <= '0;
      slot_q        <= '0;
      shift_q       <= '0;
      lrclk_q       <= 1'b0;
      frame_start_q <= 1'b0;
      overrun_l_q   <= 1'b0;
      overrun_r_q   <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      pend_l_q      <= pend_l_d;
      pend_r_q      <= pend_r_d;
      pend_vld_l_q  <= pend_vld_l_d;
      pend_vld_r_q  <= pend_vld_r_d;
      last_l_q      <= last_l_d;
      last_r_q      <= last_r_d;
      slot_q        <= slot_d;
      shift_q       <= shift_d;
      lrclk_q       <= lrclk_d;
      frame_start_q <= frame_start_d;
      overrun_l_q   <= overrun_l_d;
      overrun_r_q   <= overrun_r_d;
      underrun_q    <= underrun_d;
    end
  end

  assign bus.i2s_bclk    = bclk;
  assign bus.i2s_lrclk   = lrclk_q;
  assign bus.i2s_sdata   = shift_q[I2S_SLOTS-1];
  assign bus.frame_start = frame_start_q;
  assign bus.overrun_l   = overrun_l_q;
  assign bus.overrun_r   = overrun_r_q;
  assign bus.underrun    = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: frame-arithmetic model checked every cycle, a BCLK-driven
// receiver that rebuilds each frame, and directed scenarios with literal words.
module tb_i2s_tx;

  localparam int DIV   = 4;
  localparam int FRAME = 64 * DIV;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  i2s_tx_if bus ();

  i2s_tx #(.BCLK_DIV(DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: output state follows from edge count since reset and the frame contents
  int          n = 0;
  logic        m_pf_l = 1'b0, m_pf_r = 1'b0;
  logic [15:0] m_pv_l = '0, m_pv_r = '0, m_last_l = '0, m_last_r = '0;
  logic        e_bclk = 1'b0, e_lr = 1'b0, e_sd = 1'b0, e_fs = 1'b0;
  logic        e_ovl = 1'b0, e_ovr = 1'b0, e_ur = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n = 0;
      m_pf_l = 0; m_pf_r = 0; m_pv_l = 0; m_pv_r = 0; m_last_l = 0; m_last_r = 0;
      e_bclk = 0; e_lr = 0; e_sd = 0; e_fs = 0; e_ovl = 0; e_ovr = 0; e_ur = 0;
    end else begin
      int  slot;
      logic load;
      n++;
      load  = (n % FRAME) == 2 * DIV;
      e_ovl = bus.valid_in_l && m_pf_l && !load;
      e_ovr = bus.valid_in_r && m_pf_r && !load;
      e_fs  = load;
      e_ur  = load && !(m_pf_l && m_pf_r);
      if (load) begin
        if (m_pf_l) m_last_l = m_pv_l;
        if (m_pf_r) m_last_r = m_pv_r;
        m_pf_l = 0;
        m_pf_r = 0;
      end
      if (bus.valid_in_l) begin m_pv_l = bus.audio_in_l; m_pf_l = 1; end
      if (bus.valid_in_r) begin m_pv_r = bus.audio_in_r; m_pf_r = 1; end
      slot   = (n / (2 * DIV)) % 32;
      e_bclk = ((n / DIV) % 2) == 1;
      e_lr   = slot >= 16;
      if (slot == 0)       e_sd = m_last_r[0];
      else if (slot <= 16) e_sd = m_last_l[16 - slot];
      else                 e_sd = m_last_r[32 - slot];
    end
  end

  always @(negedge clk) begin
    chk("bclk",      bus.i2s_bclk,    e_bclk);
    chk("lrclk",     bus.i2s_lrclk,   e_lr);
    chk("sdata",     bus.i2s_sdata,   e_sd);
    chk("frame_st",  bus.frame_start, e_fs);
    chk("overrun_l", bus.overrun_l,   e_ovl);
    chk("overrun_r", bus.overrun_r,   e_ovr);
    chk("underrun",  bus.underrun,    e_ur);
  end

  // Receiver: a frame is complete at the rising BCLK where LRCLK has just gone 1->0
  logic [31:0] rx = '0;
  logic        lr_prev = 1'b0;
  logic [31:0] frames[$];
  int          ovl_cnt = 0, ovr_cnt = 0;

  always @(posedge bus.i2s_bclk) begin
    rx = {rx[30:0], bus.i2s_sdata};
    if (lr_prev && !bus.i2s_lrclk) frames.push_back(rx);
    lr_prev = bus.i2s_lrclk;
  end

  always @(negedge clk) begin
    if (bus.overrun_l) ovl_cnt++;
    if (bus.overrun_r) ovr_cnt++;
  end

  task automatic pulse(input logic le, input logic [15:0] lv, input logic re, input logic [15:0] rv);
    @(negedge clk);
    bus.valid_in_l = le; bus.audio_in_l = lv;
    bus.valid_in_r = re; bus.audio_in_r = rv;
    @(negedge clk);
    bus.valid_in_l = 1'b0;
    bus.valid_in_r = 1'b0;
  endtask

  task automatic wait_fs(input string name, input logic exp_ur);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (bus.frame_start) break;
    end
    chk({name, "_fs"}, bus.frame_start, 1);
    chk({name, "_ur"}, bus.underrun, exp_ur);
  endtask

  // Releases reset and pins the first-frame timing edge by edge; ends in the frame_start cycle
  task automatic release_and_count(input string tag);
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk);
      #1;
      if (e == 3) chk({tag, "_bclk_e3"}, bus.i2s_bclk, 0);
      if (e == 4) chk({tag, "_bclk_e4"}, bus.i2s_bclk, 1);
      if (e == 7) chk({tag, "_fs_e7"}, bus.frame_start, 0);
      if (e == 8) begin
        chk({tag, "_fs_e8"}, bus.frame_start, 1);
        chk({tag, "_ur_e8"}, bus.underrun, 1);
        chk({tag, "_bclk_e8"}, bus.i2s_bclk, 0);
        chk({tag, "_sd_e8"}, bus.i2s_sdata, 0);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_frames [8];
    exp_frames = '{32'h0000_0000, 32'h8001_7FFE, 32'h5678_7FFE, 32'h00FF_FF00,
                   32'h00FF_FF00, 32'hAAAA_1111, 32'hAAAA_4321, 32'h0000_0000};

    rst_n = 1'b1;
    bus.valid_in_l = 1'b0; bus.audio_in_l = '0;
    bus.valid_in_r = 1'b0; bus.audio_in_r = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_bclk",  bus.i2s_bclk, 0);
    chk("rst_lrclk", bus.i2s_lrclk, 0);
    chk("rst_sdata", bus.i2s_sdata, 0);
    chk("rst_fs",    bus.frame_start, 0);
    chk("rst_ur",    bus.underrun, 0);
    repeat (3) @(negedge clk);
    release_and_count("f0");

    pulse(1, 16'h8001, 1, 16'h7FFE);
    wait_fs("f1", 0);

    pulse(1, 16'h1234, 0, 16'h0);
    repeat (10) @(negedge clk);
    pulse(1, 16'h5678, 0, 16'h0);
    wait_fs("f2", 1);
    chk("ovl_cnt_t3", 32'(ovl_cnt), 1);

    pulse(1, 16'h00FF, 1, 16'hFF00);
    wait_fs("f3", 0);
    wait_fs("f4", 1);

    // Right valid lands exactly on the next load edge
    pulse(1, 16'hAAAA, 1, 16'h1111);
    repeat (253) @(negedge clk);
    bus.valid_in_r = 1'b1; bus.audio_in_r = 16'h4321;
    @(negedge clk);
    bus.valid_in_r = 1'b0;
    chk("f5_fs", bus.frame_start, 1);
    chk("f5_ur", bus.underrun, 0);
    wait_fs("f6", 1);
    chk("ovr_cnt_t5", 32'(ovr_cnt), 0);

    pulse(1, 16'hFFFF, 1, 16'hFFFF);
    wait_fs("f7", 0);
    pulse(1, 16'h1357, 0, 16'h0);
    repeat (76) @(negedge clk);
    chk("pre_rst_bclk",  bus.i2s_bclk, 1);
    chk("pre_rst_sdata", bus.i2s_sdata, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_bclk",  bus.i2s_bclk, 0);
    chk("mid_rst_sdata", bus.i2s_sdata, 0);
    chk("mid_rst_lrclk", bus.i2s_lrclk, 0);
    repeat (2) @(negedge clk);
    release_and_count("r0");
    wait_fs("r1", 1);

    chk("frame_count", 32'(frames.size()), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < frames.size()) chk($sformatf("frame%0d", i), frames[i], exp_frames[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
